multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl_pkg.sv | 80 ++++++++
 rtl/multicycle_ctrl_if.sv | 47 ++++
 rtl/multicycle_ctrl_alu_op_dec.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
//  Module      : multicycle_ctrl_pkg
//  Description : Shared encodings for the multicycle RV32I controller.
//                Contains opcode constants, the FSM state type, ALU operation
//                codes, PC/write-back select codes, and small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

  // Major opcodes (instr[6:0]) handled by the controller
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_STOP = 3'd5
  } state_t;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'd0;
  localparam alu_op_t ALU_SUB  = 4'd1;
  localparam alu_op_t ALU_SLL  = 4'd2;
  localparam alu_op_t ALU_SLT  = 4'd3;
  localparam alu_op_t ALU_SLTU = 4'd4;
  localparam alu_op_t ALU_XOR  = 4'd5;
  localparam alu_op_t ALU_SRL  = 4'd6;
  localparam alu_op_t ALU_SRA  = 4'd7;
  localparam alu_op_t ALU_OR   = 4'd8;
  localparam alu_op_t ALU_AND  = 4'd9;

  localparam logic [1:0] PC_SRC_SEQ  = 2'd0;  // PC + 4
  localparam logic [1:0] PC_SRC_REL  = 2'd1;  // PC + imm
  localparam logic [1:0] PC_SRC_JALR = 2'd2;  // (rs1 + imm) & ~1

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  function automatic logic opc_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // size = funct3[1:0]: 0 byte, 1 half, otherwise word
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Controller <-> datapath bundle.
//                master (controller): inputs instr, br_taken, addr_lo,
//                mem_rdy; drives every enable/select plus instr_done/halt/err.
//                slave (datapath/memories): the mirror image.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if #(
  parameter int ALU_OP_W = 4
);
  logic [31:0]         instr;
  logic                br_taken;
  logic [1:0]          addr_lo;
  logic                mem_rdy;
  logic                i_mem_csn;
  logic                ir_we;
  logic                pc_we;
  logic [1:0]          pc_src;
  logic                alu_src_a;
  logic                alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic                d_mem_csn;
  logic                d_mem_wen;
  logic [3:0]          d_mem_be;
  logic                rf_we;
  logic [1:0]          wb_sel;
  logic                instr_done;
  logic                halt;
  logic                err;

  modport master (
    input  instr, br_taken, addr_lo, mem_rdy,
    output i_mem_csn, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
           d_mem_csn, d_mem_wen, d_mem_be, rf_we, wb_sel, instr_done, halt, err
  );

  modport slave (
    output instr, br_taken, addr_lo, mem_rdy,
    input  i_mem_csn, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
           d_mem_csn, d_mem_wen, d_mem_be, rf_we, wb_sel, instr_done, halt, err
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_alu_op_dec.sv
// ============================================================================
//  Module      : multicycle_ctrl_alu_op_dec
//  Description : Combinational ALU operation decode.
//  Ports       : i_opcode[6:0], i_funct3[2:0], i_funct7b5 -> o_alu_op
//                OP/OP-IMM decode funct3/funct7[5]; everything else is ADD.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_alu_op_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output alu_op_t    o_alu_op
);

  logic w_is_op;
  assign w_is_op = (i_opcode == OPC_OP);

  always_comb begin
    o_alu_op = ALU_ADD;
    if (w_is_op || (i_opcode == OPC_OPIMM)) begin
      case (i_funct3)
        // funct7[5] on ADDI is immediate data, not a SUB selector
        3'b000:  o_alu_op = (w_is_op && i_funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  o_alu_op = ALU_SLL;
        3'b010:  o_alu_op = ALU_SLT;
        3'b011:  o_alu_op = ALU_SLTU;
        3'b100:  o_alu_op = ALU_XOR;
        3'b101:  o_alu_op = i_funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  o_alu_op = ALU_OR;
        default: o_alu_op = ALU_AND;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : IF/ID/EX/MEM/WB sequencer for the shared RV32I datapath.
//  Ports       : clk, rst (async, active-high), bus (multicycle_ctrl_if.master)
//  Parameters  : HALT_INSTR - IR value that parks the core in STOP
//                ALU_OP_W   - width of the ALU operation code
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_INSTR = 32'h0000_8067,
  parameter int          ALU_OP_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_if.master     bus
);

  state_t              r_state;
  state_t              w_nxt;
  logic                w_halt_set;
  logic                w_err_set;

  logic                r_i_mem_csn;
  logic                r_d_mem_csn;
  logic                r_d_mem_wen;
  logic [3:0]          r_d_mem_be;
  logic                r_rf_we;
  logic                r_pc_we;
  logic                r_instr_done;
  logic [1:0]          r_pc_src;
  logic [1:0]          r_wb_sel;
  logic                r_alu_src_a;
  logic                r_alu_src_b;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic                r_halt;
  logic                r_err;

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic       w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr;
  logic       w_ir_we, w_store_done;
  alu_op_t    w_alu_op;

  assign w_opc       = bus.instr[6:0];
  assign w_f3        = bus.instr[14:12];
  assign w_is_load   = (w_opc == OPC_LOAD);
  assign w_is_store  = (w_opc == OPC_STORE);
  assign w_is_branch = (w_opc == OPC_BRANCH);
  assign w_is_jal    = (w_opc == OPC_JAL);
  assign w_is_jalr   = (w_opc == OPC_JALR);

  multicycle_ctrl_alu_op_dec u_alu_op_dec (
    .i_opcode   (w_opc),
    .i_funct3   (w_f3),
    .i_funct7b5 (bus.instr[30]),
    .o_alu_op   (w_alu_op)
  );

  // Next state; alignment is judged on the EX-cycle address so a bad
  // access never raises d_mem_csn.
  always_comb begin
    w_nxt      = r_state;
    w_halt_set = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      ST_IF:  if (!r_i_mem_csn && bus.mem_rdy) w_nxt = ST_ID;
      ST_ID: begin
        if (bus.instr == HALT_INSTR) begin
          w_nxt      = ST_STOP;
          w_halt_set = 1'b1;
        end else if (!opc_legal(w_opc)) begin
          w_nxt      = ST_STOP;
          w_halt_set = 1'b1;
          w_err_set  = 1'b1;
        end else begin
          w_nxt = ST_EX;
        end
      end
      ST_EX: begin
        if (w_is_branch) begin
          w_nxt = ST_IF;
        end else if (w_is_load || w_is_store) begin
          if (misaligned(w_f3[1:0], bus.addr_lo)) begin
            w_nxt      = ST_STOP;
            w_halt_set = 1'b1;
            w_err_set  = 1'b1;
          end else begin
            w_nxt = ST_MEM;
          end
        end else begin
          w_nxt = ST_WB;
        end
      end
      ST_MEM:  if (bus.mem_rdy) w_nxt = w_is_load ? ST_WB : ST_IF;
      ST_WB:   w_nxt = ST_IF;
      ST_STOP: w_nxt = ST_STOP;
      default: w_nxt = ST_IF;
    endcase
  end

  // Outputs are registered against the state being entered so they line up
  // with r_state. The first IF cycle after reset only raises the fetch
  // request; the fetch is accepted once i_mem_csn is actually low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IF;
      r_i_mem_csn  <= 1'b1;
      r_d_mem_csn  <= 1'b1;
      r_d_mem_wen  <= 1'b1;
      r_d_mem_be   <= 4'b0000;
      r_rf_we      <= 1'b0;
      r_pc_we      <= 1'b0;
      r_instr_done <= 1'b0;
      r_pc_src     <= PC_SRC_SEQ;
      r_wb_sel     <= WB_SEL_ALU;
      r_alu_src_a  <= 1'b0;
      r_alu_src_b  <= 1'b0;
      r_alu_op     <= '0;
      r_halt       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_halt       <= r_halt | w_halt_set;
      r_err        <= r_err | w_err_set;
      r_i_mem_csn  <= 1'b1;
      r_d_mem_csn  <= 1'b1;
      r_d_mem_wen  <= 1'b1;
      r_d_mem_be   <= 4'b0000;
      r_rf_we      <= 1'b0;
      r_pc_we      <= 1'b0;
      r_instr_done <= 1'b0;
      r_pc_src     <= PC_SRC_SEQ;
      r_wb_sel     <= WB_SEL_ALU;

      // ALU controls persist through MEM/WB so address/result stay stable
      if (w_nxt == ST_EX) begin
        r_alu_src_a <= (w_opc == OPC_AUIPC) || w_is_jal;
        r_alu_src_b <= !((w_opc == OPC_OP) || w_is_branch);
        r_alu_op    <= ALU_OP_W'(w_alu_op);
      end else if ((w_nxt == ST_IF) || (w_nxt == ST_STOP)) begin
        r_alu_src_a <= 1'b0;
        r_alu_src_b <= 1'b0;
        r_alu_op    <= '0;
      end

      case (w_nxt)
        ST_IF: r_i_mem_csn <= 1'b0;
        ST_EX: begin
          if (w_is_branch) begin
            r_pc_we      <= 1'b1;
            r_instr_done <= 1'b1;
          end
        end
        ST_MEM: begin
          r_d_mem_csn <= 1'b0;
          r_d_mem_wen <= !w_is_store;
          r_d_mem_be  <= (r_state == ST_MEM) ? r_d_mem_be
                                             : byte_en(w_f3[1:0], bus.addr_lo);
        end
        ST_WB: begin
          r_rf_we      <= (bus.instr[11:7] != 5'd0);
          r_pc_we      <= 1'b1;
          r_instr_done <= 1'b1;
          r_wb_sel     <= w_is_load ? WB_SEL_LOAD :
                          (w_is_jal || w_is_jalr) ? WB_SEL_PC4 : WB_SEL_ALU;
          r_pc_src     <= w_is_jal ? PC_SRC_REL :
                          w_is_jalr ? PC_SRC_JALR : PC_SRC_SEQ;
        end
        default: ;
      endcase
    end
  end

  // Strobes that must coincide with the memory handshake are qualified
  // combinationally by mem_rdy; the branch target select follows br_taken.
  assign w_ir_we      = (r_state == ST_IF) && !r_i_mem_csn && bus.mem_rdy;
  assign w_store_done = (r_state == ST_MEM) && w_is_store && bus.mem_rdy;

  assign bus.i_mem_csn  = r_i_mem_csn;
  assign bus.ir_we      = w_ir_we;
  assign bus.pc_we      = r_pc_we | w_store_done;
  assign bus.instr_done = r_instr_done | w_store_done;
  assign bus.pc_src     = ((r_state == ST_EX) && w_is_branch) ?
                          (bus.br_taken ? PC_SRC_REL : PC_SRC_SEQ) : r_pc_src;
  assign bus.alu_src_a  = r_alu_src_a;
  assign bus.alu_src_b  = r_alu_src_b;
  assign bus.alu_op     = r_alu_op;
  assign bus.d_mem_csn  = r_d_mem_csn;
  assign bus.d_mem_wen  = r_d_mem_wen;
  assign bus.d_mem_be   = r_d_mem_be;
  assign bus.rf_we      = r_rf_we;
  assign bus.wb_sel     = r_wb_sel;
  assign bus.halt       = r_halt;
  assign bus.err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed self-checking bench for multicycle_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  typedef struct {
    string      tag;
    int         lat;
    logic       rf;
    logic [1:0] wb;
    logic [1:0] pcs;
    int         memc;
    logic [3:0] be;
    logic       wen;
    logic [3:0] aop;
    logic       srcb;
  } exp_t;

  localparam logic [3:0] A_ADD = 4'd0;
  localparam logic [3:0] A_SUB = 4'd1;
  localparam logic [3:0] A_SRA = 4'd7;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  multicycle_ctrl_if #(.ALU_OP_W(4)) bus ();

  multicycle_ctrl #(
    .HALT_INSTR (32'h0000_8067),
    .ALU_OP_W   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_rdy = 1'b0;
    step();
    step();
    chk("rst.i_mem_csn", 32'(bus.i_mem_csn), 32'd1);
    chk("rst.d_mem_csn", 32'(bus.d_mem_csn), 32'd1);
    chk("rst.d_mem_wen", 32'(bus.d_mem_wen), 32'd1);
    chk("rst.strobes", {29'd0, bus.ir_we, bus.pc_we, bus.rf_we}, 32'd0);
    chk("rst.sel", {22'd0, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.wb_sel}, 32'd0);
    chk("rst.be", 32'(bus.d_mem_be), 32'd0);
    chk("rst.flags", {29'd0, bus.instr_done, bus.halt, bus.err}, 32'd0);
    rst = 1'b0;
    bus.mem_rdy = 1'b1;
    step();
  endtask

  // Drive one instruction from IF to retirement; wait_n = MEM stall cycles.
  task automatic exec(input logic [31:0] ins, input logic br, input logic [1:0] alo,
                      input int wait_n, input exp_t e);
    int   cyc, waited, csn_lo;
    bit   done;
    logic [3:0] obs_be;
    logic       obs_wen;
    exp_t cur;
    sb.push_back(e);
    bus.instr = ins; bus.br_taken = br; bus.addr_lo = alo; bus.mem_rdy = 1'b1;
    cyc = 0; waited = 0; csn_lo = 0; done = 1'b0; obs_be = 4'h0; obs_wen = 1'b1;
    for (int k = 0; k < 10 && bus.i_mem_csn !== 1'b0; k++) step();
    while (!done && cyc < 40) begin
      cyc++;
      if (bus.d_mem_csn === 1'b0) begin
        csn_lo++;
        obs_be  = bus.d_mem_be;
        obs_wen = bus.d_mem_wen;
        bus.mem_rdy = (waited >= wait_n);
        waited++;
      end else begin
        bus.mem_rdy = 1'b1;
      end
      #1;
      if (cyc == 1) chk({e.tag, ".ir_we"}, 32'(bus.ir_we), 32'd1);
      if (bus.instr_done === 1'b1) begin
        done = 1'b1;
        cur = sb.pop_front();
        chk({cur.tag, ".lat"}, 32'(cyc), 32'(cur.lat));
        chk({cur.tag, ".pc_we"}, 32'(bus.pc_we), 32'd1);
        chk({cur.tag, ".rf_we"}, 32'(bus.rf_we), 32'(cur.rf));
        chk({cur.tag, ".wb_sel"}, 32'(bus.wb_sel), 32'(cur.wb));
        chk({cur.tag, ".pc_src"}, 32'(bus.pc_src), 32'(cur.pcs));
        chk({cur.tag, ".alu_op"}, 32'(bus.alu_op), 32'(cur.aop));
        chk({cur.tag, ".alu_src_b"}, 32'(bus.alu_src_b), 32'(cur.srcb));
        chk({cur.tag, ".mem_cycles"}, 32'(csn_lo), 32'(cur.memc));
        if (cur.memc > 0) begin
          chk({cur.tag, ".be"}, 32'(obs_be), 32'(cur.be));
          chk({cur.tag, ".wen"}, 32'(obs_wen), 32'(cur.wen));
        end
      end
      step();
    end
    if (!done) chk({e.tag, ".timeout"}, 32'd0, 32'd1);
  endtask

  // Drive an instruction expected to park the core in STOP.
  task automatic run_to_stop(input string tag, input logic [31:0] ins, input logic [1:0] alo,
                             input logic exp_err, input int exp_cyc);
    int cyc;
    bit dcsn_seen;
    bus.instr = ins; bus.addr_lo = alo; bus.br_taken = 1'b0; bus.mem_rdy = 1'b1;
    cyc = 0; dcsn_seen = 1'b0;
    for (int k = 0; k < 10 && bus.i_mem_csn !== 1'b0; k++) step();
    while (cyc < 20) begin
      cyc++;
      #1;
      if (bus.d_mem_csn === 1'b0) dcsn_seen = 1'b1;
      if (bus.halt === 1'b1) break;
      step();
    end
    chk({tag, ".halt_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, ".err"}, 32'(bus.err), 32'(exp_err));
    chk({tag, ".no_dmem"}, 32'(dcsn_seen), 32'd0);
    for (int k = 0; k < 4; k++) begin
      bus.mem_rdy = 1'($urandom_range(0, 1));
      step();
    end
    #1;
    chk({tag, ".sticky"}, {28'd0, bus.halt, bus.err, bus.i_mem_csn, bus.d_mem_csn},
        {28'd0, 1'b1, exp_err, 1'b1, 1'b1});
    chk({tag, ".quiet"}, {28'd0, bus.ir_we, bus.pc_we, bus.rf_we, bus.instr_done}, 32'd0);
    do_reset();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.instr = 32'h0; bus.br_taken = 1'b0; bus.addr_lo = 2'b00; bus.mem_rdy = 1'b0;
    @(negedge clk);
    do_reset();

    //            tag       lat rf    wb     pcs    memc be       wen   aop    srcb
    exec(32'h0050_0093, 1'b0, 2'd0, 0, '{"addi",   4, 1'b1, 2'd0, 2'd0, 0, 4'h0,    1'b1, A_ADD, 1'b1});
    exec(32'h0000_0463, 1'b1, 2'd0, 0, '{"beq_t",  3, 1'b0, 2'd0, 2'd1, 0, 4'h0,    1'b1, A_ADD, 1'b0});
    exec(32'h0000_0463, 1'b0, 2'd0, 0, '{"beq_n",  3, 1'b0, 2'd0, 2'd0, 0, 4'h0,    1'b1, A_ADD, 1'b0});
    exec(32'h0000_2103, 1'b0, 2'd0, 3, '{"lw",     8, 1'b1, 2'd1, 2'd0, 4, 4'hF,    1'b1, A_ADD, 1'b1});
    exec(32'h0010_0123, 1'b0, 2'd2, 0, '{"sb",     4, 1'b0, 2'd0, 2'd0, 1, 4'b0100, 1'b0, A_ADD, 1'b1});
    exec(32'h0010_1123, 1'b0, 2'd2, 0, '{"sh",     4, 1'b0, 2'd0, 2'd0, 1, 4'b1100, 1'b0, A_ADD, 1'b1});
    exec(32'h0000_4183, 1'b0, 2'd3, 1, '{"lbu",    6, 1'b1, 2'd1, 2'd0, 2, 4'b1000, 1'b1, A_ADD, 1'b1});
    exec(32'h0080_00EF, 1'b0, 2'd0, 0, '{"jal",    4, 1'b1, 2'd2, 2'd1, 0, 4'h0,    1'b1, A_ADD, 1'b1});
    exec(32'h0040_8067, 1'b0, 2'd0, 0, '{"jalr_x0",4, 1'b0, 2'd2, 2'd2, 0, 4'h0,    1'b1, A_ADD, 1'b1});
    exec(32'h4020_81B3, 1'b0, 2'd0, 0, '{"sub",    4, 1'b1, 2'd0, 2'd0, 0, 4'h0,    1'b1, A_SUB, 1'b0});
    exec(32'h4030_D093, 1'b0, 2'd0, 0, '{"srai",   4, 1'b1, 2'd0, 2'd0, 0, 4'h0,    1'b1, A_SRA, 1'b1});
    exec(32'hC000_0093, 1'b0, 2'd0, 0, '{"addi_neg",4,1'b1, 2'd0, 2'd0, 0, 4'h0,    1'b1, A_ADD, 1'b1});
    chk("sb.empty", 32'(sb.size()), 32'd0);

    run_to_stop("halt",   32'h0000_8067, 2'd0, 1'b0, 3);
    run_to_stop("illegal",32'h0000_007F, 2'd0, 1'b1, 3);
    run_to_stop("sh_mis", 32'h0010_1123, 2'd1, 1'b1, 4);
    run_to_stop("lw_mis", 32'h0000_2103, 2'd2, 1'b1, 4);

    // Reset in the middle of a stalled store
    bus.instr = 32'h0010_2023; bus.addr_lo = 2'd0; bus.mem_rdy = 1'b1;
    for (int k = 0; k < 10 && bus.d_mem_csn !== 1'b0; k++) step();
    bus.mem_rdy = 1'b0;
    chk("rstmem.pre_csn", 32'(bus.d_mem_csn), 32'd0);
    chk("rstmem.pre_wen", 32'(bus.d_mem_wen), 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("rstmem.csn", 32'(bus.d_mem_csn), 32'd1);
    chk("rstmem.wen", 32'(bus.d_mem_wen), 32'd1);
    chk("rstmem.strobes", {30'd0, bus.pc_we, bus.instr_done}, 32'd0);
    step();
    rst = 1'b0;
    bus.mem_rdy = 1'b1;
    step();
    #1;
    chk("rstmem.refetch", {30'd0, bus.i_mem_csn, bus.ir_we}, {30'd0, 1'b0, 1'b1});
    chk("rstmem.flags", {30'd0, bus.halt, bus.err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
